sc_dot_product_counted: RTL and testbench
=========================================

# sc_dot_product_counted

Parametrised stochastic dot-product engine that multiplies LENGTH data/weight bitstreams, scale-adds them with an internally generated random mux select, and counts the ones in the result over a programmable stream length. It supports unipolar (AND) and bipolar (XNOR) multiply modes. It also emits the per-beat result stream. It replaces the bare combinational dot product with a self-contained start/done unit for use in stochastic layer datapaths.

## Interface
- LENGTH, 4, number of product lanes; must equal 2**SELECT_WIDTH (elaboration error otherwise)
- SELECT_WIDTH, 2, mux select width, 1..16
- LEN_W, 8, width of stream_len and count
- BIPOLAR, 0, 0 = unipolar AND multiply, 1 = bipolar XNOR multiply
- LFSR_SEED, 16'hACE1, reset/reseed value of select LFSR; must be nonzero

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- stream_len  in  LEN_W  beats per run; latched on accepted start
- in_valid  in  1  data/weights beat present
- in_ready  out  1  high throughout RUN
- data  in  LENGTH  one bit per lane, current beat
- weights  in  LENGTH  one bit per lane, current beat
- busy  out  1  high in RUN and DONE
- bit_valid  out  1  bit_out carries an accepted beat's result
- bit_out  out  1  selected product bit of the accepted beat
- done  out  1  one-cycle pulse at end of run
- count  out  LEN_W  number of ones in the run; held until next accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches stream_len and clears count to 0. Goes to DONE if stream_len==0, otherwise to RUN with remaining=stream_len.
- RUN: a beat is accepted when in_valid && in_ready.
- Per accepted beat:
  - prod[i] = data[i]&weights[i] (BIPOLAR=0) or ~(data[i]^weights[i]) (BIPOLAR=1).
  - b = prod[sel], with sel = lfsr[SELECT_WIDTH-1:0].
  - count += b; remaining -= 1; LFSR advances one step.
- The beat accepted with remaining==1 moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored while busy. in_valid is ignored outside RUN.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left.
  - New bit 0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Advances only on accepted beats.
  - Not reseeded between runs, only by rst.
- count cannot overflow: count ≤ stream_len ≤ 2**LEN_W-1.

## Timing
- Reset values: in_ready=0, busy=0, bit_valid=0, bit_out=0, done=0, count=0, state=IDLE, lfsr=LFSR_SEED.
- Start sampled at edge k:
  - busy and in_ready are high from cycle k+1.
  - For a zero-length run, done is high in cycle k+1 and the FSM is back in IDLE at k+2.
- Beat accepted at edge j: bit_valid/bit_out are registered and visible in cycle j+1, and count includes b from cycle j+1.
- Final beat accepted at edge j:
  - Cycle j+1: done=1, in_ready=0, final count visible, bit_valid for the final bit.
  - Cycle j+2: busy=0.
- Minimum run time with in_valid held high: N+1 cycles from start edge to done cycle.
- rst asserted mid-run:
  - Next cycle: IDLE, all outputs at reset values, lfsr=LFSR_SEED.
  - The partial count is discarded.
- If rst and start are high on the same edge, rst wins.

## Test plan
- Unipolar, data=4'hF, weights=4'hF, stream_len=100, in_valid=1, start at edge 0 -> bit_out=1 every beat, done in cycle 101, count=100.
- Unipolar, data=4'h0, weights=4'hF, stream_len=50 -> count=0, done in cycle 51. Bipolar, data=4'h0, weights=4'h0, stream_len=50 -> count=50. Bipolar, data=4'hF, weights=4'h0 -> count=0.
- Unipolar, data=4'b0011, weights=4'hF, stream_len=255 from reset -> count equals the bench LFSR model's number of beats with sel∈{0,1} (≈128); bit_out matches the model beat-for-beat.
- in_valid toggling 1,0,1,0…, stream_len=10 -> exactly 10 bit_valid pulses; done 20 cycles after start; LFSR advances only on accepted beats (model match).
- stream_len=0 -> done in cycle 1, count=0, no bit_valid. A start pulse during RUN is ignored: count and the done cycle are unchanged.
- rst at beat 30 of a 100-beat run -> next cycle all outputs 0 and IDLE. A new 100-beat run with data=weights=4'hF gives count=100 and a bit_out sequence identical to the first run from reset.

Source files
------------

// File: rtl/sc_dot_product_counted.sv
// sc_dot_product_counted
//   Stochastic dot-product engine with start/done handshake. Each accepted
//   beat multiplies LENGTH data/weight bit pairs (AND for unipolar, XNOR for
//   bipolar), picks one product with a pseudo-random select taken from an
//   internal 16-bit LFSR (the scaled add), emits that bit, and counts the
//   ones over a programmable number of beats.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin a run (IDLE only); latches stream_len
//   stream_len  in   beats per run
//   in_valid    in   beat present on data/weights
//   in_ready    out  high throughout RUN
//   data        in   one bit per lane
//   weights     in   one bit per lane
//   busy        out  high in RUN and DONE
//   bit_valid   out  bit_out carries an accepted beat's result
//   bit_out     out  selected product bit of the accepted beat
//   done        out  one-cycle pulse at end of run
//   count       out  ones counted in the run, held until next start
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting beats until remaining reaches zero
// DONE  | one-cycle done pulse, then back to IDLE

module sc_dot_product_counted #(
  parameter int          LENGTH       = 4,
  parameter int          SELECT_WIDTH = 2,
  parameter int          LEN_W        = 8,
  parameter int          BIPOLAR      = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  stream_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] data,
  input  logic [LENGTH-1:0] weights,
  output logic              busy,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  if (LENGTH != (1 << SELECT_WIDTH)) begin : g_bad_length
    $error("sc_dot_product_counted: LENGTH must equal 2**SELECT_WIDTH");
  end
  if (SELECT_WIDTH < 1 || SELECT_WIDTH > 16) begin : g_bad_select
    $error("sc_dot_product_counted: SELECT_WIDTH must be 1..16");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("sc_dot_product_counted: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [LEN_W-1:0]        r_remaining;
  logic [LEN_W-1:0]        r_count;
  logic [15:0]             r_lfsr;
  logic                    r_in_ready;
  logic                    r_busy;
  logic                    r_bit_valid;
  logic                    r_bit_out;
  logic                    r_done;

  logic [LENGTH-1:0]       w_prod;
  logic [SELECT_WIDTH-1:0] w_sel;
  logic                    w_bit;
  logic                    w_accept;
  logic [15:0]             w_lfsr_next;

  assign w_prod      = (BIPOLAR != 0) ? ~(data ^ weights) : (data & weights);
  assign w_sel       = r_lfsr[SELECT_WIDTH-1:0];
  assign w_bit       = w_prod[w_sel];
  // in_ready is only high in RUN, so this is the full acceptance condition.
  assign w_accept    = in_valid && r_in_ready;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_count     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count     <= '0;
            r_remaining <= stream_len;
            r_busy      <= 1'b1;
            if (stream_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_bit_valid <= 1'b1;
            r_bit_out   <= w_bit;
            r_count     <= r_count + {{(LEN_W-1){1'b0}}, w_bit};
            r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
            r_lfsr      <= w_lfsr_next;
            if (r_remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign bit_valid = r_bit_valid;
  assign bit_out   = r_bit_out;
  assign done      = r_done;
  assign count     = r_count;

endmodule

// File: tb/tb_sc_dot_product_counted.sv
module tb_sc_dot_product_counted;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] stream_len;
  logic [3:0] data, weights;

  logic       in_ready_u, busy_u, bit_valid_u, bit_out_u, done_u;
  logic [7:0] count_u;
  logic       in_ready_b, busy_b, bit_valid_b, bit_out_b, done_b;
  logic [7:0] count_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  sc_dot_product_counted #(.LENGTH(4), .SELECT_WIDTH(2), .LEN_W(8), .BIPOLAR(0), .LFSR_SEED(16'hACE1)) u_uni (
    .clk(clk), .rst(rst), .start(start), .stream_len(stream_len), .in_valid(in_valid),
    .in_ready(in_ready_u), .data(data), .weights(weights), .busy(busy_u),
    .bit_valid(bit_valid_u), .bit_out(bit_out_u), .done(done_u), .count(count_u));

  sc_dot_product_counted #(.LENGTH(4), .SELECT_WIDTH(2), .LEN_W(8), .BIPOLAR(1), .LFSR_SEED(16'hACE1)) u_bip (
    .clk(clk), .rst(rst), .start(start), .stream_len(stream_len), .in_valid(in_valid),
    .in_ready(in_ready_b), .data(data), .weights(weights), .busy(busy_b),
    .bit_valid(bit_valid_b), .bit_out(bit_out_b), .done(done_b), .count(count_b));

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".u_in_ready"},  in_ready_u,  0);
    chk({tag, ".u_busy"},      busy_u,      0);
    chk({tag, ".u_bit_valid"}, bit_valid_u, 0);
    chk({tag, ".u_bit_out"},   bit_out_u,   0);
    chk({tag, ".u_done"},      done_u,      0);
    chk({tag, ".u_count"},     count_u,     0);
    chk({tag, ".b_busy"},      busy_b,      0);
    chk({tag, ".b_count"},     count_b,     0);
  endtask

  // One run driven from IDLE. The bench tracks remaining beats, expected bits
  // and count with its own LFSR model; exp_cnt >= 0 adds a hand-computed check.
  task automatic do_run(input string tag, input logic [7:0] len, input logic [3:0] d,
                        input logic [3:0] w, input bit toggle, input bit bip,
                        input int start_at, input int exp_cnt);
    int         rem, cnt, cyc, pulses;
    logic [3:0] p;
    logic       iv, b;
    data = d; weights = w; stream_len = len; start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    rem = len; cnt = 0; cyc = 1; pulses = 0;
    p = bip ? ~(d ^ w) : (d & w);
    chk({tag, ".busy1"}, bip ? busy_b : busy_u, 1);
    if (len == 0) begin
      chk({tag, ".done1"},  bip ? done_b : done_u, 1);
      chk({tag, ".ready1"}, bip ? in_ready_b : in_ready_u, 0);
      chk({tag, ".bv1"},    bip ? bit_valid_b : bit_valid_u, 0);
      chk({tag, ".cnt1"},   bip ? count_b : count_u, 0);
    end else begin
      chk({tag, ".ready1"}, bip ? in_ready_b : in_ready_u, 1);
      while (rem > 0 && cyc < 1000) begin
        iv = toggle ? cyc[0] : 1'b1;
        in_valid = iv;
        if (cyc == start_at) begin
          start = 1'b1;
          stream_len = 8'd5;
        end
        b = 1'b0;
        if (iv) begin
          b = p[lfsr_m[1:0]];
          lfsr_m = lfsr_step(lfsr_m);
          cnt += int'(b);
          rem--;
        end
        tick();
        start = 1'b0;
        cyc++;
        if (bip ? bit_valid_b : bit_valid_u) pulses++;
        chk($sformatf("%s.bv@%0d", tag, cyc), bip ? bit_valid_b : bit_valid_u, iv);
        if (iv) chk($sformatf("%s.bit@%0d", tag, cyc), bip ? bit_out_b : bit_out_u, b);
        chk($sformatf("%s.cnt@%0d", tag, cyc), bip ? count_b : count_u, cnt);
        chk($sformatf("%s.done@%0d", tag, cyc), bip ? done_b : done_u, rem == 0);
        chk($sformatf("%s.ready@%0d", tag, cyc), bip ? in_ready_b : in_ready_u, rem != 0);
      end
      if (rem != 0) begin
        miscompares++;
        $error("FAIL %s.timeout: observed %0d beats left expected 0", tag, rem);
      end
      chk({tag, ".pulses"}, pulses, len);
      if (exp_cnt >= 0) chk({tag, ".final"}, bip ? count_b : count_u, exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    chk({tag, ".busy_end"}, bip ? busy_b : busy_u, 0);
    chk({tag, ".done_end"}, bip ? done_b : done_u, 0);
    chk({tag, ".cnt_hold"}, bip ? count_b : count_u, cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    stream_len = '0; data = '0; weights = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    lfsr_m = 16'hACE1;

    // model-driven: only lanes 0 and 1 produce ones
    do_run("lfsr255", 8'd255, 4'b0011, 4'hF, 1'b0, 1'b0, 0, -1);
    do_run("uni_ff",  8'd100, 4'hF, 4'hF, 1'b0, 1'b0, 0, 100);
    do_run("uni_0f",  8'd50,  4'h0, 4'hF, 1'b0, 1'b0, 0, 0);
    do_run("bip_00",  8'd50,  4'h0, 4'h0, 1'b0, 1'b1, 0, 50);
    do_run("bip_f0",  8'd50,  4'hF, 4'h0, 1'b0, 1'b1, 0, 0);
    do_run("toggle",  8'd10,  4'b0011, 4'hF, 1'b1, 1'b0, 0, -1);
    do_run("zero",    8'd0,   4'hF, 4'hF, 1'b0, 1'b0, 0, 0);
    do_run("midstart", 8'd20, 4'hF, 4'hF, 1'b0, 1'b0, 3, 20);

    // reset 30 beats into a 100-beat run
    data = 4'hF; weights = 4'hF; stream_len = 8'd100; start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("pre_rst.cnt", count_u, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_all_zero("midrst");
    lfsr_m = 16'hACE1;

    // reset beats start on the same edge
    rst = 1'b1; start = 1'b1; stream_len = 8'd10;
    tick();
    rst = 1'b0; start = 1'b0;
    chk_all_zero("rst_start");

    do_run("post_ff",  8'd100, 4'hF, 4'hF, 1'b0, 1'b0, 0, 100);
    lfsr_m = 16'hACE1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_run("reseed255", 8'd255, 4'b0011, 4'hF, 1'b0, 1'b0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
